trellis_traceback: RTL
======================

Name: trellis_traceback

Overview:
- Survivor-path traceback unit for the 20-state trellis demodulator. It is the reader side of the best-metric search.
- The ACS array writes one survivor vector per symbol into a circular buffer.
- On each best-state strobe, the block starts at the winning state index, walks TB_LEN symbols back through the stored predecessor pointers and emits one decided bit.
- It sits between the max-metric selector (index, delayed symbol enable) and the bit output path.

Parameters:
- TB_LOG2, 4: log2 of traceback depth; TB_LEN = 2**TB_LOG2 buffered symbols.
- NSTATES, 20: trellis states per survivor vector; fixed at 20 for this trellis.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- symEn  input  1  write strobe; survIn is valid this cycle.
- survIn  input  120  survivor vector. Slot s = bits [6s+5:6s] for s = 0..19. Slot bits [4:0] are the predecessor state; slot bit 5 is the decided bit on that branch.
- startEn  input  1  traceback start strobe (delayed symbol enable from the max-metric selector).
- index  input  5  winning state (0..19), sampled when startEn=1.
- decBit  output  1  decided bit from the oldest buffered symbol.
- decEn  output  1  one-clock strobe; decBit is valid.
- busy  output  1  high while a traceback is in progress.
- overrun  output  1  one-clock pulse; traceback aborted by a write.

Behaviour:
- Reset (asynchronous): wrPtr=0, fillCnt=0, FSM=IDLE, decBit=0, decEn=0, busy=0, overrun=0. Buffer contents are don't-care and need no reset.
- Write:
  - On symEn, survIn is stored at buf[wrPtr] and wrPtr increments modulo TB_LEN (wraps TB_LEN-1 -> 0).
  - fillCnt increments and saturates at TB_LEN.
  - A write is always performed, in any FSM state.
- State sanitising: any index or predecessor value of 20..31 is treated as state 0.
- FSM IDLE:
  - startEn is accepted only if fillCnt, including a write in the same cycle, equals TB_LEN. Otherwise it is ignored: no trace, no decEn.
  - On accept: state <= index; rdPtr <= newest entry; cnt <= 0; go to TRACE; busy=1 from the next cycle.
  - Newest entry is wrPtr when symEn is high in the same cycle (write-then-read); otherwise it is wrPtr-1 mod TB_LEN.
- FSM TRACE (one buffer entry per clock). Each cycle, read slot[state] of buf[rdPtr]:
  - If cnt == TB_LEN-1: decBit <= slot bit 5; decEn <= 1 for one clock; go to IDLE; busy=0.
  - Else: state <= slot predecessor; rdPtr <= rdPtr-1 mod TB_LEN; cnt <= cnt+1.
- Latency: decEn is high exactly TB_LEN+1 clocks after the cycle startEn was accepted (17 clocks at default).
- Decided bit source: the entry TB_LEN-1 symbols older than the newest.
- Throughput: symEn and startEn spacing must be ≥ TB_LEN+2 clocks.
- Conflicts during TRACE:
  - symEn during TRACE overwrites the oldest entry. The trace is aborted: overrun pulses one clock, FSM returns to IDLE, no decEn. The write still completes.
  - startEn during TRACE is ignored; the trace continues.
  - If symEn and startEn arrive together during TRACE, only the abort applies.
- Reset mid-trace: immediate return to IDLE, outputs cleared, fillCnt=0; warm-up restarts.
- decBit holds its last value between strobes.

Test Plan (TB_LOG2=2, TB_LEN=4 unless noted):
- Warm-up:
  - Stimulus: 3 writes, then startEn with index=5.
  - Required: no busy, no decEn.
  - Stimulus: 4th write plus startEn in the same cycle.
  - Required: trace starts; decEn 5 clocks later.
- Identity trellis:
  - Stimulus: writes k=0..3 with every slot pred=s and bit=k[0]; startEn index=7 after write k=3.
  - Required: decEn with decBit=0.
  - Stimulus: write k=4 (bit=0) + startEn.
  - Required: decBit=1 (oldest entry is k=1); confirms wrap-around.
- Path following:
  - Stimulus: newest entry slot 19 pred=3. Next older entry: slot 3 pred=12; all its other slots pred=0, bit=0. Next older entry: slot 12 pred=8. Oldest entry: slot 8 bit=1, all other slots bit=0. startEn index=19.
  - Required: decBit=1.
- Sanitising:
  - Stimulus: index=25 with slot 0 chain giving oldest bit=1.
  - Required: decBit=1.
  - Stimulus: a predecessor value of 31.
  - Required: it follows state 0.
- Overrun:
  - Stimulus: symEn 2 clocks after startEn.
  - Required: overrun pulse 1 clock; busy drops; no decEn; the next start after a clean write traces normally.
- Reset mid-trace:
  - Stimulus: assert reset at TRACE cycle 2.
  - Required: busy=0, decEn=0 immediately. After release, 4 writes are needed before the next startEn is accepted.

Source files
------------

// File: rtl/trellis_traceback.sv
// Survivor-path traceback: stores one survivor vector per symbol in a
// circular buffer and, on each best-state strobe, walks TB_LEN entries back
// from the winning state to emit one decided bit.
module trellis_traceback #(
    parameter int TB_LOG2 = 4,
    parameter int NSTATES = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   symEn,
    input  logic [6*NSTATES-1:0]   survIn,
    input  logic                   startEn,
    input  logic [4:0]             index,
    output logic                   decBit,
    output logic                   decEn,
    output logic                   busy,
    output logic                   overrun
);
    localparam int TB_LEN = 2**TB_LOG2;
    localparam logic [TB_LOG2:0]   FULL = (TB_LOG2+1)'(TB_LEN);
    localparam logic [TB_LOG2-1:0] LAST = TB_LOG2'(TB_LEN-1);

    typedef enum logic {IDLE, TRACE} fsm_t;

    // Each entry is NSTATES slots of {decided bit, predecessor[4:0]}.
    logic [TB_LEN-1:0][NSTATES-1:0][5:0] r_buf;

    fsm_t               r_fsm, w_fsmNext;
    logic [TB_LOG2-1:0] r_wrPtr;
    logic [TB_LOG2:0]   r_fillCnt, w_fillNext;
    logic [4:0]         r_tstate, w_tstateNext;
    logic [TB_LOG2-1:0] r_rdPtr, w_rdPtrNext;
    logic [TB_LOG2-1:0] r_cnt, w_cntNext;
    logic               r_decBit, w_decBitNext;
    logic               r_decEn, w_decEnNext;
    logic               r_overrun, w_overrunNext;
    logic [5:0]         w_slot;

    // Out-of-range state numbers (20..31) fold onto state 0.
    function automatic logic [4:0] f_san(input logic [4:0] s);
        return (s >= 5'(NSTATES)) ? 5'd0 : s;
    endfunction

    // Fill level as it will be after this cycle's write (saturating).
    assign w_fillNext = (symEn && r_fillCnt != FULL) ? r_fillCnt + 1'b1 : r_fillCnt;
    assign w_slot     = r_buf[r_rdPtr][r_tstate];

    // Buffer storage: written on every symEn regardless of FSM state.
    always_ff @(posedge clk) begin
        if (symEn) r_buf[r_wrPtr] <= survIn;
    end

    // Write pointer and fill counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr   <= '0;
            r_fillCnt <= '0;
        end else begin
            if (symEn) r_wrPtr <= r_wrPtr + 1'b1;
            r_fillCnt <= w_fillNext;
        end
    end

    // FSM state and traceback datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fsm     <= IDLE;
            r_tstate  <= '0;
            r_rdPtr   <= '0;
            r_cnt     <= '0;
            r_decBit  <= 1'b0;
            r_decEn   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_fsm     <= w_fsmNext;
            r_tstate  <= w_tstateNext;
            r_rdPtr   <= w_rdPtrNext;
            r_cnt     <= w_cntNext;
            r_decBit  <= w_decBitNext;
            r_decEn   <= w_decEnNext;
            r_overrun <= w_overrunNext;
        end
    end

    // Next-state: accept a start once the buffer is full, then follow
    // predecessors one entry per clock; a write mid-trace aborts it because
    // it overwrites the entry the walk will end on.
    always_comb begin
        w_fsmNext     = r_fsm;
        w_tstateNext  = r_tstate;
        w_rdPtrNext   = r_rdPtr;
        w_cntNext     = r_cnt;
        w_decBitNext  = r_decBit;
        w_decEnNext   = 1'b0;
        w_overrunNext = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (startEn && w_fillNext == FULL) begin
                    w_fsmNext    = TRACE;
                    w_tstateNext = f_san(index);
                    // Same-cycle write is the newest entry (write-then-read).
                    w_rdPtrNext  = symEn ? r_wrPtr : r_wrPtr - 1'b1;
                    w_cntNext    = '0;
                end
            end
            TRACE: begin
                if (symEn) begin
                    w_overrunNext = 1'b1;
                    w_fsmNext     = IDLE;
                end else if (r_cnt == LAST) begin
                    w_decBitNext = w_slot[5];
                    w_decEnNext  = 1'b1;
                    w_fsmNext    = IDLE;
                end else begin
                    w_tstateNext = f_san(w_slot[4:0]);
                    w_rdPtrNext  = r_rdPtr - 1'b1;
                    w_cntNext    = r_cnt + 1'b1;
                end
            end
            default: w_fsmNext = IDLE;
        endcase
    end

    assign busy    = (r_fsm == TRACE);
    assign decBit  = r_decBit;
    assign decEn   = r_decEn;
    assign overrun = r_overrun;

endmodule
